vga_pin_driver: RTL and testbench



---
 rtl/vga_pin_driver_if.sv | 26 ++
 rtl/vga_pin_driver.sv | 122 ++++++++++++
 tb/tb_vga_pin_driver.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_pin_driver_if.sv
// Pixel/sync/audio bundle between the demo generator (master) and the pin driver (slave).
// The driver reduces IN_BITS-per-channel colour to the 2-bit pmod pins.
interface vga_pin_driver_if #(
   parameter int unsigned IN_BITS = 4
);
   logic [3*IN_BITS-1:0] rgb;
   logic                 hsync;
   logic                 vsync;
   logic                 blank;
   logic                 pwm_in;
   logic [1:0]           mode;
   logic [7:0]           uo_out;
   logic [7:0]           uio_out;
   logic [7:0]           uio_oe;
   logic                 pix_en;

   modport master (
      output rgb, hsync, vsync, blank, pwm_in, mode,
      input  uo_out, uio_out, uio_oe, pix_en
   );

   modport slave (
      input  rgb, hsync, vsync, blank, pwm_in, mode,
      output uo_out, uio_out, uio_oe, pix_en
   );
endinterface

// File: rtl/vga_pin_driver.sv
// Registered TinyVGA/audio pin stage: pixel divider, blanking, sync polarity and
// colour reduction to 2 bits per channel (truncate, ordered or frame-rotating dither).
module vga_pin_driver #(
   parameter int unsigned IN_BITS   = 4,
   parameter int unsigned PIXEL_DIV = 2,
   parameter bit          HSYNC_NEG = 1'b1,
   parameter bit          VSYNC_NEG = 1'b1
) (
   input logic            clk,
   input logic            rst_n,
   vga_pin_driver_if.slave bus
);
   localparam int unsigned   DivW    = (PIXEL_DIV > 1) ? $clog2(PIXEL_DIV) : 1;
   localparam int unsigned   FracW   = IN_BITS - 2;
   localparam logic [DivW-1:0] DivLast = DivW'(PIXEL_DIV - 1);
   localparam logic [7:0]    UoRst   = {HSYNC_NEG, 3'b000, VSYNC_NEG, 3'b000};

   logic [DivW-1:0] div_cnt_q, div_cnt_d;
   logic            x_par_q, x_par_d;
   logic            y_par_q, y_par_d;
   logic [1:0]      frame_q, frame_d;
   logic            hs_d_q, hs_d_d;
   logic            vs_d_q, vs_d_d;
   logic [7:0]      uo_q, uo_d;
   logic [7:0]      uio_q, uio_d;

   logic               pix_en;
   logic [1:0]         bayer, t2;
   logic               dith;
   logic [IN_BITS-1:0] r_in, g_in, b_in;
   logic [1:0]         r_o, g_o, b_o;

   assign r_in = bus.rgb[3*IN_BITS-1 -: IN_BITS];
   assign g_in = bus.rgb[2*IN_BITS-1 -: IN_BITS];
   assign b_in = bus.rgb[IN_BITS-1:0];

   // Threshold is t2 left-aligned into the fraction width; with no fraction bits the
   // comparison is always false, so every mode collapses to truncation.
   function automatic logic [1:0] reduce_chan(input logic [IN_BITS-1:0] v,
                                              input logic [1:0] thr_idx,
                                              input logic dither);
      logic [1:0]  hi;
      int unsigned frac, th, sum;
      hi   = v[IN_BITS-1 -: 2];
      frac = 32'(v) & ((32'd1 << FracW) - 32'd1);
      th   = (32'(thr_idx) << FracW) >> 2;
      sum  = 32'(hi) + ((dither && (frac > th)) ? 32'd1 : 32'd0);
      reduce_chan = (sum > 32'd3) ? 2'd3 : sum[1:0];
   endfunction

   always_comb begin
      pix_en    = (div_cnt_q == '0);
      div_cnt_d = (div_cnt_q == DivLast) ? '0 : div_cnt_q + 1'b1;

      bayer = {x_par_q ^ y_par_q, y_par_q};
      t2    = bayer;
      dith  = 1'b0;
      case (bus.mode)
         2'd1:    dith = 1'b1;
         2'd2: begin
            dith = 1'b1;
            t2   = bayer + frame_q;
         end
         default: dith = 1'b0;
      endcase

      r_o = reduce_chan(r_in, t2, dith);
      g_o = reduce_chan(g_in, t2, dith);
      b_o = reduce_chan(b_in, t2, dith);
      if (bus.blank) begin
         r_o = 2'd0;
         g_o = 2'd0;
         b_o = 2'd0;
      end

      x_par_d = x_par_q;
      y_par_d = y_par_q;
      frame_d = frame_q;
      hs_d_d  = hs_d_q;
      vs_d_d  = vs_d_q;
      uo_d    = uo_q;
      if (pix_en) begin
         uo_d    = {bus.hsync ^ HSYNC_NEG, b_o[0], g_o[0], r_o[0],
                    bus.vsync ^ VSYNC_NEG, b_o[1], g_o[1], r_o[1]};
         x_par_d = ~bus.blank & ~x_par_q;
         y_par_d = bus.vsync ? 1'b0 : (y_par_q ^ (bus.hsync & ~hs_d_q));
         frame_d = frame_q + {1'b0, bus.vsync & ~vs_d_q};
         hs_d_d  = bus.hsync;
         vs_d_d  = bus.vsync;
      end

      // Audio bypasses the pixel strobe.
      uio_d = {bus.pwm_in, 7'b0};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q <= '0;
         x_par_q   <= 1'b0;
         y_par_q   <= 1'b0;
         frame_q   <= 2'd0;
         hs_d_q    <= 1'b0;
         vs_d_q    <= 1'b0;
         uo_q      <= UoRst;
         uio_q     <= 8'h00;
      end else begin
         div_cnt_q <= div_cnt_d;
         x_par_q   <= x_par_d;
         y_par_q   <= y_par_d;
         frame_q   <= frame_d;
         hs_d_q    <= hs_d_d;
         vs_d_q    <= vs_d_d;
         uo_q      <= uo_d;
         uio_q     <= uio_d;
      end
   end

   assign bus.uo_out  = uo_q;
   assign bus.uio_out = uio_q;
   assign bus.uio_oe  = 8'h80;
   assign bus.pix_en  = pix_en;
endmodule

// File: tb/tb_vga_pin_driver.sv
// Scoreboard bench: several parameterisations of vga_pin_driver driven with random
// pixels/syncs; expected pins come from an arithmetic reference model.
module tb_vga_pin_driver;
   localparam int          NCfg           = 4;
   localparam int unsigned CfgIn  [NCfg]  = '{4, 6, 3, 2};
   localparam int unsigned CfgDiv [NCfg]  = '{2, 3, 1, 1};
   localparam bit          CfgHn  [NCfg]  = '{1'b1, 1'b0, 1'b1, 1'b0};
   localparam bit          CfgVn  [NCfg]  = '{1'b1, 1'b0, 1'b0, 1'b1};
   localparam int          Cycles         = 400;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int tot_cmp = 0;
   int tot_bad = 0;

   for (genvar gi = 0; gi < NCfg; gi++) begin : g_cfg
      localparam int unsigned IB    = CfgIn[gi];
      localparam int unsigned DIV   = CfgDiv[gi];
      localparam bit          HN    = CfgHn[gi];
      localparam bit          VN    = CfgVn[gi];
      localparam logic [7:0]  RstUo = {HN, 3'b000, VN, 3'b000};

      logic rst_n = 1'b1;

      vga_pin_driver_if #(.IN_BITS(IB)) bus ();

      vga_pin_driver #(
         .IN_BITS  (IB),
         .PIXEL_DIV(DIV),
         .HSYNC_NEG(HN),
         .VSYNC_NEG(VN)
      ) u_dut (
         .clk  (clk),
         .rst_n(rst_n),
         .bus  (bus)
      );

      logic [7:0] exp_q[$];
      bit         pix_q[$];
      bit         pwm_q[$];
      bit         stim_done = 1'b0;
      bit         fin       = 1'b0;
      bit         closed    = 1'b0;
      int         n_cmp     = 0;
      int         n_bad     = 0;

      // Reference model state: pixel count since reset, parities, frame, previous syncs.
      int unsigned k, xp, yp, fr;
      bit          hsp, vsp;

      function automatic logic [1:0] ref_chan(int unsigned v, int unsigned md);
         int unsigned fw, hi, frac, t, t2, th, o;
         fw   = IB - 2;
         hi   = v >> fw;
         frac = v % (1 << fw);
         if (md != 1 && md != 2) return 2'(hi);
         t    = 2 * (xp ^ yp) + yp;
         t2   = (md == 2) ? (t + fr) % 4 : t;
         th   = (fw >= 2) ? (t2 << (fw - 2)) : (t2 >> (2 - fw));
         o    = hi + ((frac > th) ? 1 : 0);
         return 2'((o > 3) ? 3 : o);
      endfunction

      initial begin : stim
         int unsigned ch[3];
         logic [1:0]  q[3];
         logic [7:0]  e;
         bus.rgb    = '0;
         bus.hsync  = 1'b0;
         bus.vsync  = 1'b0;
         bus.blank  = 1'b0;
         bus.pwm_in = 1'b0;
         bus.mode   = 2'd0;
         #1 rst_n = 1'b0;
         // Second pass asserts reset in the middle of a running stream.
         for (int ph = 0; ph < 2; ph++) begin
            rst_n = 1'b0;
            exp_q.delete();
            pix_q.delete();
            pwm_q.delete();
            k   = 0;
            xp  = 0;
            yp  = 0;
            fr  = 0;
            hsp = 1'b0;
            vsp = 1'b0;
            repeat (3) @(posedge clk);
            #2 rst_n = 1'b1;
            for (int c = 0; c < Cycles; c++) begin
               for (int j = 0; j < 3; j++) ch[j] = $urandom_range(0, (1 << IB) - 1);
               if ($urandom_range(0, 3) == 0) begin
                  ch[1] = ch[0];
                  ch[2] = ch[0];
               end
               bus.rgb    = {IB'(ch[0]), IB'(ch[1]), IB'(ch[2])};
               if ($urandom_range(0, 7) == 0)  bus.hsync = ~bus.hsync;
               if ($urandom_range(0, 19) == 0) bus.vsync = ~bus.vsync;
               bus.blank  = ($urandom_range(0, 3) == 0);
               bus.mode   = 2'($urandom_range(0, 3));
               bus.pwm_in = 1'($urandom_range(0, 1));
               if (k % DIV == 0) begin
                  for (int j = 0; j < 3; j++) q[j] = bus.blank ? 2'd0 : ref_chan(ch[j], bus.mode);
                  e = {bus.hsync ^ HN, q[2][0], q[1][0], q[0][0],
                       bus.vsync ^ VN, q[2][1], q[1][1], q[0][1]};
                  exp_q.push_back(e);
                  xp = bus.blank ? 0 : (xp ^ 1);
                  if (bus.vsync)                  yp = 0;
                  else if (bus.hsync && !hsp)     yp = yp ^ 1;
                  if (bus.vsync && !vsp)          fr = (fr + 1) % 4;
                  hsp = bus.hsync;
                  vsp = bus.vsync;
               end
               pix_q.push_back(k % DIV == 0);
               pwm_q.push_back(bus.pwm_in);
               k++;
               @(posedge clk);
               #2;
            end
         end
         stim_done = 1'b1;
         @(posedge clk);
         @(posedge clk);
         #1 fin = 1'b1;
      end

      bit         rec  = 1'b0;
      bit         live = 1'b0;
      bit         pbit;
      logic [7:0] last = RstUo;

      task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
         n_cmp++;
         tot_cmp++;
         if (act !== expv) begin
            n_bad++;
            tot_bad++;
            $display("FAIL cfg%0d %s: got %0h expected %0h at %0t", gi, nm, act, expv, $time);
         end
      endtask

      task automatic miss(string nm);
         n_cmp++;
         tot_cmp++;
         n_bad++;
         tot_bad++;
         $display("FAIL cfg%0d %s: got output with nothing expected at %0t", gi, nm, $time);
      endtask

      always @(negedge clk) begin
         if (!fin) begin
            if (!rst_n) begin
               chk("reset uo_out", 32'(bus.uo_out), 32'(RstUo));
               chk("reset uio_out", 32'(bus.uio_out), 32'h0);
               chk("uio_oe", 32'(bus.uio_oe), 32'h80);
               rec  = 1'b0;
               live = 1'b0;
               last = RstUo;
            end else begin
               if (live) begin
                  if (pwm_q.size() > 0) begin
                     pbit = pwm_q.pop_front();
                     chk("pwm uio_out", 32'(bus.uio_out), {24'd0, pbit, 7'd0});
                  end else if (!stim_done) begin
                     miss("pwm queue empty");
                  end
                  if (rec) begin
                     if (exp_q.size() > 0) begin
                        last = exp_q.pop_front();
                        chk("pixel uo_out", 32'(bus.uo_out), 32'(last));
                     end else if (!stim_done) begin
                        miss("strobe without pixel");
                     end
                  end else begin
                     chk("hold uo_out", 32'(bus.uo_out), 32'(last));
                  end
               end
               if (pix_q.size() > 0) begin
                  pbit = pix_q.pop_front();
                  chk("pix_en", 32'(bus.pix_en), 32'(pbit));
               end else if (!stim_done) begin
                  miss("pix queue empty");
               end
               rec  = bus.pix_en;
               live = 1'b1;
            end
         end else if (!closed) begin
            chk("leftover pixels", 32'(exp_q.size()), 32'd0);
            closed = 1'b1;
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got timeout expected all configurations to finish");
      $fatal(1, "simulation timeout");
   end

   initial begin : summary
      wait (g_cfg[0].closed && g_cfg[1].closed && g_cfg[2].closed && g_cfg[3].closed);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", tot_cmp, tot_bad);
      $finish;
   end
endmodule
